uart_rx_frame: RTL and testbench

- RS485 receive-side counterpart of the team's 15/16-byte burst UART transmitter.
- Deserialises bursts of FRAME_BYTES bytes. Line format: 8 data bits LSB first, start bit 0, one or more stop bits 1, no parity.
- Uses an oversampling clock and holds the last complete frame in a double buffer for downstream logic to read by index.
- Sits between the RS485 transceiver RO pin and the packet/telemetry consumer.

---
 rtl/uart_rx_pkg.sv | 19 +
 rtl/uart_rx_byte.sv | 127 ++++++++++++
 rtl/uart_rx_frame.sv | 126 ++++++++++++
 tb/tb_uart_rx_frame.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the RS485 burst UART receiver.
`timescale 1ns/1ps
package uart_rx_pkg;

    localparam int BYTE_W           = 8;
    localparam int IDX_W            = 4;
    localparam int DEF_OVERSAMPLE   = 16;
    localparam int DEF_GAP_BITS     = 22;
    localparam int DEF_FRAME_BYTES  = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// Byte deserialiser: rx synchroniser, start/data/stop FSM and shift register.
// Strobes (start_o, valid_o, ferr_o) are single-cycle registered pulses.
`timescale 1ns/1ps
module uart_rx_byte
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_i,
    output logic              start_o,
    output logic              valid_o,
    output logic [BYTE_W-1:0] data_o,
    output logic              ferr_o,
    output logic              busy_o,
    output rx_state_e         state_o
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OVERSAMPLE - 1);

    rx_state_e         state_q;
    logic              sync_q;
    logic              rxs_q;
    logic              rxs_prev_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        bit_q;
    logic [BYTE_W-1:0] shift_q;
    logic              start_q;
    logic              valid_q;
    logic              ferr_q;
    logic              busy_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            sync_q     <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            start_q    <= 1'b0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync_q     <= rx_i;
            rxs_q      <= sync_q;
            rxs_prev_q <= rxs_q;
            start_q    <= 1'b0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rxs_prev_q && !rxs_q) begin
                        state_q <= START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        start_q <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == HALF_CNT) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        // A line already back high at mid-start-bit was a glitch.
                        if (rxs_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q   <= '0;
                        shift_q <= {rxs_q, shift_q[BYTE_W-1:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q  <= '0;
                        busy_q <= 1'b0;
                        if (rxs_q) begin
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                BREAK: begin
                    if (rxs_q) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign start_o = start_q;
    assign valid_o = valid_q;
    assign data_o  = shift_q;
    assign ferr_o  = ferr_q;
    assign busy_o  = busy_q;
    assign state_o = state_q;

endmodule

// File: rtl/uart_rx_frame.sv
// Frame assembler: slot index, inter-byte gap timer, assembly/output double
// buffer and the registered read port for downstream consumers.
`timescale 1ns/1ps
module uart_rx_frame
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
    parameter int FRAME_BYTES = DEF_FRAME_BYTES,
    parameter int GAP_BITS    = DEF_GAP_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic [IDX_W-1:0]  rd_addr,
    output logic [BYTE_W-1:0] rd_data,
    output logic              byte_valid,
    output logic [BYTE_W-1:0] byte_data,
    output logic [IDX_W-1:0]  byte_index,
    output logic              frame_done,
    output logic              frame_err,
    output logic              busy
);

    localparam int NSLOT   = 1 << IDX_W;
    localparam int GAP_MAX = GAP_BITS * OVERSAMPLE;
    localparam int GAP_W   = $clog2(GAP_MAX + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    logic              b_start;
    logic              b_valid;
    logic [BYTE_W-1:0] b_data;
    logic              b_ferr;
    logic              b_busy;
    rx_state_e         rx_state;

    uart_rx_byte #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_byte (
        .clk     (clk),
        .reset   (reset),
        .rx_i    (rx),
        .start_o (b_start),
        .valid_o (b_valid),
        .data_o  (b_data),
        .ferr_o  (b_ferr),
        .busy_o  (b_busy),
        .state_o (rx_state)
    );

    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              frame_err_q, frame_err_d;
    logic              gap_hit;
    logic              last_slot;
    logic [BYTE_W-1:0] asm_q [NSLOT];
    logic [BYTE_W-1:0] out_q [NSLOT];

    assign last_slot = (wr_idx_q == LAST_IDX);
    assign gap_hit   = (gap_q == GAP_W'(GAP_MAX));

    always_comb begin
        wr_idx_d    = wr_idx_q;
        gap_d       = gap_q;
        frame_err_d = frame_err_q;

        // The gap timer only runs while a partial frame is pending.
        if (b_start) begin
            gap_d       = '0;
            frame_err_d = 1'b0;
        end else if (rx_state == IDLE && wr_idx_q != '0) begin
            gap_d = gap_hit ? gap_q : gap_q + GAP_W'(1);
        end else begin
            gap_d = '0;
        end

        if (b_valid) begin
            wr_idx_d = last_slot ? '0 : wr_idx_q + IDX_W'(1);
        end else if (b_ferr) begin
            wr_idx_d    = '0;
            frame_err_d = 1'b1;
        end else if (gap_hit && !b_start) begin
            wr_idx_d    = '0;
            gap_d       = '0;
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_idx_q    <= '0;
            gap_q       <= '0;
            frame_err_q <= 1'b0;
            byte_valid  <= 1'b0;
            byte_data   <= '0;
            byte_index  <= '0;
            frame_done  <= 1'b0;
            rd_data     <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                asm_q[i] <= '0;
                out_q[i] <= '0;
            end
        end else begin
            wr_idx_q    <= wr_idx_d;
            gap_q       <= gap_d;
            frame_err_q <= frame_err_d;
            byte_valid  <= b_valid;
            frame_done  <= b_valid && last_slot;
            if (b_valid) begin
                byte_data         <= b_data;
                byte_index        <= wr_idx_q;
                asm_q[wr_idx_q]   <= b_data;
                // The closing byte bypasses asm_q so the whole frame moves at once.
                if (last_slot) begin
                    for (int i = 0; i < NSLOT; i++) begin
                        out_q[i] <= (IDX_W'(i) == wr_idx_q) ? b_data : asm_q[i];
                    end
                end
            end
            rd_data <= ({1'b0, rd_addr} < (IDX_W + 1)'(FRAME_BYTES)) ? out_q[rd_addr] : '0;
        end
    end

    assign frame_err = frame_err_q;
    assign busy      = b_busy;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: byte-level reference model, per-cycle
// compare process, and literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_uart_rx_frame;

    localparam int      FB = 16;
    localparam realtime BT = 160.0;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_data;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic [3:0] byte_index;
    logic       frame_done;
    logic       frame_err;
    logic       busy;

    uart_rx_frame dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_index (byte_index),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- counters and checks ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_cond(input string name, input bit ok,
                              input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        check_cond(name, act === req, act, req);
    endtask

    // ---------------- reference model ----------------
    logic [11:0]  exp_q[$];
    logic [127:0] exp_frame_q[$];
    logic [7:0]   m_asm [FB];
    logic [7:0]   m_out [FB];
    int           m_idx = 0;
    bit           m_err = 1'b0;
    int           frames_exp = 0;
    int           frames_seen = 0;
    bit           started = 1'b0;

    task automatic model_reset();
        m_idx = 0;
        m_err = 1'b0;
        for (int i = 0; i < FB; i++) begin
            m_asm[i] = 8'h00;
            m_out[i] = 8'h00;
        end
        exp_q.delete();
        exp_frame_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] d, input bit stop_ok);
        logic [127:0] f;
        m_err = 1'b0;
        if (stop_ok) begin
            exp_q.push_back({4'(m_idx), d});
            m_asm[m_idx] = d;
            if (m_idx == FB - 1) begin
                for (int i = 0; i < FB; i++) begin
                    f[i*8 +: 8] = m_asm[i];
                    m_out[i]    = m_asm[i];
                end
                exp_frame_q.push_back(f);
                frames_exp++;
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end else begin
            m_err = 1'b1;
            m_idx = 0;
        end
    endtask

    task automatic model_gap();
        if (m_idx != 0) begin
            m_err = 1'b1;
            m_idx = 0;
        end
    endtask

    // ---------------- compare process ----------------
    logic [7:0] view [FB];
    logic [7:0] snap [FB];
    logic [3:0] snap_addr = 4'd0;

    initial begin
        for (int i = 0; i < FB; i++) begin
            view[i] = 8'h00;
            snap[i] = 8'h00;
        end
    end

    always @(negedge clk) begin : cmp
        logic [11:0]  e;
        logic [127:0] f;
        if (started) begin
            check("rd_data", 32'(rd_data), 32'(snap[snap_addr]));
            if (byte_valid) begin
                if (exp_q.size() == 0) begin
                    check_cond("unexpected_byte_valid", 1'b0, 32'(byte_data), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("byte_data", 32'(byte_data), 32'(e[7:0]));
                    check("byte_index", 32'(byte_index), 32'(e[11:8]));
                    check("err_after_accept", 32'(frame_err), 32'(0));
                end
            end
            if (frame_done) begin
                frames_seen++;
                check("frame_done_align", 32'(byte_valid), 32'(1));
                if (exp_frame_q.size() == 0) begin
                    check_cond("unexpected_frame_done", 1'b0, 32'(1), 32'(0));
                end else begin
                    f = exp_frame_q.pop_front();
                    for (int i = 0; i < FB; i++) view[i] = f[i*8 +: 8];
                end
            end
        end
        if (!reset) begin
            for (int i = 0; i < FB; i++) view[i] = 8'h00;
        end
        for (int i = 0; i < FB; i++) snap[i] = view[i];
        snap_addr = rd_addr;
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] d, input bit stop_ok,
                             input int n_stop, input realtime bt);
        model_byte(d, stop_ok);
        rx = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(bt);
        end
        rx = stop_ok;
        #(bt);
        rx = 1'b1;
        for (int i = 1; i < n_stop; i++) #(bt);
    endtask

    task automatic send_partial(input logic [7:0] d, input int bits);
        rx = 1'b0;
        #(BT);
        for (int i = 0; i < bits; i++) begin
            rx = d[i];
            #(BT);
        end
        rx = d[bits];
        #(BT / 2);
    endtask

    task automatic read_check(input logic [3:0] a, input logic [7:0] expv, input string name);
        @(posedge clk);
        #2 rd_addr = a;
        @(posedge clk);
        #1 check(name, 32'(rd_data), 32'(expv));
    endtask

    task automatic scan_frame();
        for (int a = 0; a < FB; a++) read_check(4'(a), m_out[a], "scan_out_buf");
    endtask

    task automatic check_outputs_zero();
        check("rst_rd_data", 32'(rd_data), 32'(0));
        check("rst_byte_valid", 32'(byte_valid), 32'(0));
        check("rst_byte_data", 32'(byte_data), 32'(0));
        check("rst_byte_index", 32'(byte_index), 32'(0));
        check("rst_frame_done", 32'(frame_done), 32'(0));
        check("rst_frame_err", 32'(frame_err), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int busy_cnt;
        model_reset();
        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1 started = 1'b1;
        @(negedge clk);
        check_outputs_zero();
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (20) @(posedge clk);

        // Frame 0x00..0x0F with two stop bits
        for (int i = 0; i < FB; i++) send_byte(8'(i), 1'b1, 2, BT);
        #(2 * BT);
        check("frames_after_first", 32'(frames_seen), 32'(1));
        read_check(4'd5, 8'h05, "rd_addr5");
        read_check(4'd15, 8'h0F, "rd_addr15");
        scan_frame();

        // Short low glitch on an idle line
        @(negedge clk);
        busy_cnt = 0;
        rx = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (c == 3) rx = 1'b1;
        end
        check_cond("glitch_busy_len", busy_cnt >= 1 && busy_cnt <= 10, 32'(busy_cnt), 32'(10));
        check("glitch_frame_err", 32'(frame_err), 32'(0));

        // Framing error, then a full frame of 0x3C
        send_byte(8'hA5, 1'b0, 1, BT);
        #(3 * BT);
        check("ferr_model", 32'(frame_err), 32'(m_err));
        check("ferr_set", 32'(frame_err), 32'(1));
        for (int i = 0; i < FB; i++) send_byte(8'h3C, 1'b1, 2, BT);
        #(2 * BT);
        check("ferr_cleared", 32'(frame_err), 32'(0));
        for (int a = 0; a < FB; a++) read_check(4'(a), 8'h3C, "buf_3c");

        // Partial frame aborted by the gap timer
        for (int i = 0; i < 7; i++) send_byte(8'(8'h20 + i), 1'b1, 2, BT);
        #(24 * BT);
        model_gap();
        check("gap_err_model", 32'(frame_err), 32'(m_err));
        check("gap_err_set", 32'(frame_err), 32'(1));
        read_check(4'd0, 8'h3C, "gap_buf_kept");
        for (int i = 0; i < FB; i++) send_byte(8'(8'h40 + i), 1'b1, 2, BT);
        #(2 * BT);
        read_check(4'd6, 8'h46, "gap_next_frame");
        scan_frame();

        // Reset in the middle of bit 4 of byte 9
        for (int i = 0; i < 9; i++) send_byte(8'(8'h90 + i), 1'b1, 1, BT);
        send_partial(8'h99, 4);
        @(posedge clk);
        #2;
        reset = 1'b0;
        rx    = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_outputs_zero();
        @(posedge clk);
        #2 reset = 1'b1;
        read_check(4'd3, 8'h00, "post_reset_buf");
        for (int i = 0; i < FB; i++) send_byte(8'(8'hC0 ^ i), 1'b1, 2, BT);
        #(2 * BT);
        scan_frame();

        // Back-to-back single stop bit with fast and slow baud skew
        for (int k = 0; k < 2; k++) begin
            realtime bt;
            bt = (k == 0) ? BT * 0.97 : BT * 1.03;
            for (int i = 0; i < FB; i++) send_byte(8'((i * 37 + 11) ^ (k * 8'h5A)), 1'b1, 1, bt);
            #(3 * BT);
            scan_frame();
        end

        repeat (50) @(posedge clk);
        check("bytes_drained", 32'(exp_q.size()), 32'(0));
        check("frames_drained", 32'(exp_frame_q.size()), 32'(0));
        check("frame_count", 32'(frames_seen), 32'(frames_exp));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
